// File: rtl/ddr_pixel_writer_pkg.sv
// Shared definitions for the DDR frame-buffer ports: resolution switch codes,
// per-resolution pixel totals, MCB instruction codes and the writer FSM states.
package ddr_pixel_writer_pkg;

  localparam logic [3:0] SW_VGA      = 4'b0000;
  localparam logic [3:0] SW_SVGA     = 4'b0001;
  localparam logic [3:0] SW_HDTV720P = 4'b0010;
  localparam logic [3:0] SW_XGA      = 4'b0011;
  localparam logic [3:0] SW_SXGA     = 4'b0100;

  localparam logic [20:0] TOTAL_VGA      = 21'd307200;
  localparam logic [20:0] TOTAL_SVGA     = 21'd480000;
  localparam logic [20:0] TOTAL_XGA      = 21'd786432;
  localparam logic [20:0] TOTAL_HDTV720P = 21'd921600;
  localparam logic [20:0] TOTAL_SXGA     = 21'd1310720;

  localparam logic [2:0] MCB_WRITE = 3'b000;
  localparam logic [2:0] MCB_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_WAIT_CAL,
    ST_FILL,
    ST_ISSUE
  } wr_state_t;

  // Unknown switch codes fall back to the largest frame.
  function automatic logic [20:0] res_total(input logic [3:0] code);
    case (code)
      SW_VGA:      res_total = TOTAL_VGA;
      SW_SVGA:     res_total = TOTAL_SVGA;
      SW_XGA:      res_total = TOTAL_XGA;
      SW_HDTV720P: res_total = TOTAL_HDTV720P;
      default:     res_total = TOTAL_SXGA;
    endcase
  endfunction

endpackage

// File: rtl/ddr_pixel_writer_decoder.sv
// Registered resolution lookup: latches the frame pixel total when update is
// sampled high. TOTAL_OVERRIDE (non-zero) forces a fixed total for short frames.
module resolution_decoder
  import ddr_pixel_writer_pkg::*;
#(
  parameter logic [20:0] TOTAL_OVERRIDE = 21'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  resolution,
  input  logic        update,
  output logic [20:0] total_pixels
);

  localparam logic [20:0] RESET_TOTAL = (TOTAL_OVERRIDE != 21'd0) ? TOTAL_OVERRIDE : TOTAL_VGA;

  // Reload the total only on an update request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_pixels <= RESET_TOTAL;
    end else if (update) begin
      total_pixels <= (TOTAL_OVERRIDE != 21'd0) ? TOTAL_OVERRIDE : res_total(resolution);
    end
  end

endmodule

// File: rtl/ddr_pixel_writer.sv
// Packs per-pixel iteration words into MCB write bursts and issues write
// commands at sequential frame-buffer addresses, wrapping at end of frame.
module ddr_pixel_writer
  import ddr_pixel_writer_pkg::*;
#(
  parameter int unsigned  BURST_LEN      = 64,
  parameter logic [29:0]  BASE_ADDR      = 30'd0,
  parameter logic [20:0]  TOTAL_OVERRIDE = 21'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic [3:0]  resolution,
  input  logic        update,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        wr_full,
  input  logic [6:0]  wr_count,
  input  logic        wr_underrun,
  input  logic        wr_error,
  input  logic        cmd_full,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        cmd_en,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic        frame_done,
  output logic        err
);

  localparam logic [6:0]  BL_7  = 7'(BURST_LEN);
  localparam logic [20:0] BL_21 = 21'(BURST_LEN);

  wr_state_t   state, state_nxt;
  logic        calib_p0, calib_p1;
  logic [20:0] total_pixels, ptr, remain;
  logic [6:0]  beat, burst_q, burst_calc, burst_sz;
  logic        restart_q, frame_pend;
  logic        accept, last_beat, issue_fire, wrap_hit, restart_now;
  logic        unused_status;

  assign unused_status = ^wr_count;
  assign cmd_instr     = MCB_WRITE;
  assign wr_mask       = 4'b0000;

  resolution_decoder #(.TOTAL_OVERRIDE(TOTAL_OVERRIDE)) u_res_dec (
    .clk          (clk),
    .reset        (reset),
    .resolution   (resolution),
    .update       (update),
    .total_pixels (total_pixels)
  );

  // --- stage p0/p1: calibration synchroniser ---
  // Two-flop synchroniser for the asynchronous calibration flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib_p0 <= 1'b0;
      calib_p1 <= 1'b0;
    end else begin
      calib_p0 <= mem_calib_done;
      calib_p1 <= calib_p0;
    end
  end

  // Burst size is recomputed while no beat is held, then frozen in burst_q.
  always_comb begin
    remain     = total_pixels - ptr;
    burst_calc = (remain < BL_21) ? remain[6:0] : BL_7;
    burst_sz   = (beat == 7'd0) ? burst_calc : burst_q;
  end

  // FSM outputs and handshake decode.
  always_comb begin
    pix_ready   = (state == ST_FILL) && !wr_full && (beat < burst_sz);
    accept      = pix_valid && pix_ready;
    last_beat   = accept && ((beat + 7'd1) == burst_sz);
    issue_fire  = (state == ST_ISSUE) && !cmd_full;
    wrap_hit    = (ptr + {14'd0, beat}) == total_pixels;
    restart_now = restart_q || update;
  end

  // FSM next-state: a mid-burst update commits the partial burst early.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_CAL: if (calib_p1) state_nxt = ST_FILL;
      ST_FILL:     if (last_beat || (update && (beat != 7'd0))) state_nxt = ST_ISSUE;
      ST_ISSUE:    if (!cmd_full) state_nxt = ST_FILL;
      default:     state_nxt = ST_WAIT_CAL;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_WAIT_CAL;
    else       state <= state_nxt;
  end

  // Beat counter, frame pointer and restart bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat      <= 7'd0;
      burst_q   <= 7'd0;
      ptr       <= 21'd0;
      restart_q <= 1'b0;
    end else begin
      if (issue_fire)   beat <= 7'd0;
      else if (accept)  beat <= beat + 7'd1;

      if ((state == ST_FILL) && (beat == 7'd0)) burst_q <= burst_calc;

      if (issue_fire) begin
        if (restart_now || wrap_hit) ptr <= 21'd0;
        else                         ptr <= ptr + {14'd0, beat};
      end else if (update && ((state == ST_WAIT_CAL) || ((state == ST_FILL) && (beat == 7'd0)))) begin
        ptr <= 21'd0;
      end

      if (issue_fire) restart_q <= 1'b0;
      else if (update && (((state == ST_FILL) && (beat != 7'd0)) || (state == ST_ISSUE)))
        restart_q <= 1'b1;
    end
  end

  // --- stage p1: MCB-facing registered outputs ---
  // Write data one cycle after acceptance; command strobe one cycle after the
  // last data beat; frame_done one cycle after a wrapping command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en         <= 1'b0;
      wr_data       <= 32'd0;
      cmd_en        <= 1'b0;
      cmd_bl        <= 6'd0;
      cmd_byte_addr <= 30'd0;
      frame_pend    <= 1'b0;
      frame_done    <= 1'b0;
      err           <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) wr_data <= pix_data;
      cmd_en <= issue_fire;
      if (issue_fire) begin
        cmd_bl        <= 6'(beat - 7'd1);
        cmd_byte_addr <= BASE_ADDR + {7'd0, ptr, 2'b00};
      end
      frame_pend <= issue_fire && wrap_hit && !restart_now;
      frame_done <= frame_pend;
      err        <= err | wr_underrun | wr_error;
    end
  end

endmodule
